// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with a 2-entry skid buffer.
// Ports: clk_in, rst_in (async, active-low), rdy_in (global freeze), flush,
//   up_valid/up_data/up_ready (upstream), dn_valid/dn_data/dn_ready
//   (downstream), occupancy (0..2 words held).
// Optional: PIPE_STAGE_PERF_EN adds stall_cnt and bubble_cnt counters.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W   = 64,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(64'h0000_0000_0000_0013)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_ready,
`ifdef PIPE_STAGE_PERF_EN
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`else
    output logic [1:0]        occupancy
`endif
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              up_ready_q, up_ready_d;
    logic              push, pop;

    assign dn_valid  = (state_q != ST_EMPTY);
    assign dn_data   = dn_valid ? m_q : NOP_DATA;
    assign up_ready  = up_ready_q;
    assign occupancy = state_q;

    assign push = up_valid & up_ready_q & rdy_in;
    assign pop  = dn_valid & dn_ready & rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_EMPTY;
            m_q        <= NOP_DATA;
            s_q        <= NOP_DATA;
            up_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            up_ready_q <= up_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
            m_d     = NOP_DATA;
            s_d     = NOP_DATA;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        m_d     = up_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        m_d = up_data;
                    end else if (push) begin
                        s_d     = up_data;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        m_d     = NOP_DATA;
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // up_ready is low here, so only a pop can occur.
                    if (pop) begin
                        m_d     = s_q;
                        s_d     = NOP_DATA;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_d     = NOP_DATA;
                    s_d     = NOP_DATA;
                end
            endcase
        end
        // Registered ready: derived from the next state, not from dn_ready.
        up_ready_d = (state_d != ST_TWO);
    end

`ifdef PIPE_STAGE_PERF_EN
    // Cleared by reset only; flush leaves the history intact.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (rdy_in && dn_valid && !dn_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (rdy_in && !dn_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule
